ser_tx_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one 6-bit parallel-to-serial serializer between N_REQ requesters.
- Each requester offers one DATA_W-bit word via a request/acknowledge handshake.
- The block grants one requester, presents its word to the serializer with a single-cycle valid pulse, then tracks the serializer busy flag until the shift completes.
- Sits between the framing/packet sources and the serializer instance at the top of the TX path.

---
 rtl/ser_tx_pkg.sv | 20 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/ser_shift.sv | 38 +++
 rtl/ser_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_ser_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ser_tx_pkg.sv
// rtl/ser_tx_pkg.sv - shared types and helpers for the serializer TX arbiter
package ser_tx_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Parallel width of the shared serializer
    localparam int DATA_W_DEF = 6;

    // Width of an index into n requesters (at least one bit)
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
//   req   : request vector
//   ptr   : highest-priority position; scan runs upward from here with wrap
//   grant : one-hot winner (zero when no request)
//   idx   : winner index
//   any   : at least one request present
module rr_pick
    import ser_tx_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            // First hit wins; later hits are ignored so grant stays one-hot
            if (!any && req[pos]) begin
                any        = 1'b1;
                idx        = IW'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_shift.sv
// rtl/ser_shift.sv - parallel-to-serial shifter, MSB first, busy while shifting
//   par_i  : parallel word, sampled when val_i is high and the shifter is idle
//   val_i  : load strobe
//   sd_o   : serial data, valid while busy_o is high
//   busy_o : high for exactly W cycles after a load
module ser_shift #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] par_i,
    input  logic         val_i,
    output logic         sd_o,
    output logic         busy_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (val_i && cnt_q == '0) begin
            sr_q  <= par_i;
            cnt_q <= CW'(W);
        end else if (cnt_q != '0) begin
            sr_q  <= {sr_q[W-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign sd_o   = sr_q[W-1];
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/ser_tx_arbiter.sv
// rtl/ser_tx_arbiter.sv - round-robin sequencer sharing one serializer among N_REQ requesters
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : request levels, held until acked
//   req_data_i   : packed words, requester k at [k*DATA_W +: DATA_W]
//   req_ack_o    : one-hot single-cycle take pulse
//   ser_data_o   : word to the serializer (holds last word)
//   ser_val_o    : single-cycle load pulse to the serializer
//   ser_busy_i   : serializer busy flag
//   done_o       : single-cycle completion pulse
//   done_id_o    : requester of the last completion, held
//   err_tmo_o    : sticky busy-never-rose flag
//   idle_o       : high in IDLE
module ser_tx_arbiter
    import ser_tx_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BUSY_TMO = 3,
    localparam int IDW = id_w(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ack_o,
    output logic [DATA_W-1:0]       ser_data_o,
    output logic                    ser_val_o,
    input  logic                    ser_busy_i,
    output logic                    done_o,
    output logic [IDW-1:0]          done_id_o,
    output logic                    err_tmo_o,
    output logic                    idle_o
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
    localparam logic [3:0]     TMO_LIM = 4'(BUSY_TMO);

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      gid_q, gid_d;
    logic [3:0]          tmo_q, tmo_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic                val_q, val_d;
    logic                done_q, done_d;
    logic [IDW-1:0]      did_q, did_d;
    logic                err_q, err_d;

    logic [N_REQ-1:0]    pick_grant;
    logic [IDW-1:0]      pick_idx;
    logic                pick_any;
    logic [3:0]          tmo_inc;

    // Masking with the current ack keeps a stale request from being granted twice
    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_i & ~ack_q),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign tmo_inc = tmo_q + 4'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            tmo_q    <= '0;
            ack_q    <= '0;
            sdata_q  <= '0;
            val_q    <= 1'b0;
            done_q   <= 1'b0;
            did_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            tmo_q    <= tmo_d;
            ack_q    <= ack_d;
            sdata_q  <= sdata_d;
            val_q    <= val_d;
            done_q   <= done_d;
            did_q    <= did_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        tmo_d    = tmo_q;
        ack_d    = '0;
        sdata_d  = sdata_q;
        val_d    = 1'b0;
        done_d   = 1'b0;
        did_d    = did_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                // A busy serializer is still owned elsewhere; hold off granting
                if (pick_any && !ser_busy_i) begin
                    ack_d    = pick_grant;
                    sdata_d  = req_data_i[pick_idx*DATA_W +: DATA_W];
                    val_d    = 1'b1;
                    gid_d    = pick_idx;
                    rr_ptr_d = (pick_idx == LAST_ID) ? '0 : pick_idx + IDW'(1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (ser_busy_i) begin
                    state_d = WAIT_DONE;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIM) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        did_d   = gid_q;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!ser_busy_i) begin
                    done_d  = 1'b1;
                    did_d   = gid_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ack_o  = ack_q;
    assign ser_data_o = sdata_q;
    assign ser_val_o  = val_q;
    assign done_o     = done_q;
    assign done_id_o  = did_q;
    assign err_tmo_o  = err_q;
    assign idle_o     = (state_q == IDLE);

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// tb/tb_ser_tx_arbiter.sv - self-checking bench for ser_tx_arbiter with real and stub serializer
module tb_ser_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 6;
    localparam int TMO = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ack_o;
    logic [W-1:0]   ser_data_o;
    logic           ser_val_o;
    logic           busy_dut;
    logic           done_o;
    logic [1:0]     done_id_o;
    logic           err_tmo_o;
    logic           idle_o;

    logic           stub_en;
    logic           force_busy;
    logic           sd;
    logic           ser_busy;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    always #5 clk = ~clk;

    // Stub swallows the load pulse and pins busy low; force_busy models another owner
    assign busy_dut = stub_en ? 1'b0 : (ser_busy | force_busy);

    ser_shift #(.W(W)) u_ser (
        .clk_i  (clk),
        .rst_i  (rst),
        .par_i  (ser_data_o),
        .val_i  (ser_val_o & ~stub_en),
        .sd_o   (sd),
        .busy_o (ser_busy)
    );

    ser_tx_arbiter #(.N_REQ(N), .DATA_W(W), .BUSY_TMO(TMO)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .req_data_i (req_data),
        .req_ack_o  (req_ack_o),
        .ser_data_o (ser_data_o),
        .ser_val_o  (ser_val_o),
        .ser_busy_i (busy_dut),
        .done_o     (done_o),
        .done_id_o  (done_id_o),
        .err_tmo_o  (err_tmo_o),
        .idle_o     (idle_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next winner: first pending requester at or after the pointer, circularly
    function automatic int exp_winner();
        for (int i = 0; i < N; i++) begin
            if (req[(ptr_m + i) % N]) return (ptr_m + i) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    task automatic set_word(input int k, input logic [W-1:0] w);
        req_data[k*W +: W] = w;
    endtask

    // One full transaction on the real serializer; exp_lat<=0 skips latency check
    task automatic do_txn(input int exp_id, input int exp_lat, input string tag);
        int          lat;
        int          n;
        bit          got;
        logic [W-1:0] word;
        logic [W-1:0] bits;
        word = req_data[exp_id*W +: W];
        lat  = 0;
        got  = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (req_ack_o != '0) got = 1'b1;
        end
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        if (exp_lat > 0) chk({tag, "_ack_lat"}, lat, exp_lat);
        chk({tag, "_ack"}, 32'(req_ack_o), 32'(1 << exp_id));
        chk({tag, "_val"}, 32'(ser_val_o), 32'd1);
        chk({tag, "_data"}, 32'(ser_data_o), 32'(word));
        req[exp_id] = 1'b0;
        ptr_m = (exp_id + 1) % N;
        bits = '0;
        n    = 0;
        tick();
        chk({tag, "_val_pulse"}, 32'(ser_val_o), 32'd0);
        while (ser_busy && n < 20) begin
            bits = {bits[W-2:0], sd};
            n++;
            tick();
        end
        chk({tag, "_nbits"}, n, W);
        chk({tag, "_bits"}, 32'(bits), 32'(word));
        chk({tag, "_done_early"}, 32'(done_o), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_done_id"}, 32'(done_id_o), 32'(exp_id));
    endtask

    initial begin
        int w;
        int k;
        int lat;
        bit got;
        rst        = 1'b1;
        req        = '0;
        req_data   = '0;
        stub_en    = 1'b0;
        force_busy = 1'b0;

        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_ack", 32'(req_ack_o), 32'd0);
        chk("rst_val", 32'(ser_val_o), 32'd0);
        chk("rst_data", 32'(ser_data_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_done_id", 32'(done_id_o), 32'd0);
        chk("rst_err", 32'(err_tmo_o), 32'd0);
        rst = 1'b0;
        tick();

        // Single request on requester 2
        set_word(2, 6'b101101);
        req = 4'b0100;
        do_txn(2, 1, "single");

        // All four held: strict 0,1,2,3 from a fresh pointer
        do_reset();
        set_word(0, 6'h01);
        set_word(1, 6'h02);
        set_word(2, 6'h04);
        set_word(3, 6'h08);
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            chk("all_model", exp_winner(), i);
            do_txn(i, 1, "all");
        end

        // Fairness: serve 1, pointer at 2, then 0 then 1
        set_word(1, 6'h2a);
        req = 4'b0010;
        do_txn(1, 1, "fair_a");
        set_word(0, 6'h15);
        set_word(1, 6'h33);
        req = 4'b0011;
        do_txn(0, 1, "fair_b");
        do_txn(1, 1, "fair_c");

        // Random request sets and words against the rotation model
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < N; j++) set_word(j, W'($urandom));
            req = N'($urandom_range(1, (1 << N) - 1));
            while (req != '0) begin
                w = exp_winner();
                do_txn(w, 1, "rand");
            end
        end

        // Serializer busy elsewhere: no ack until it drops
        force_busy = 1'b1;
        set_word(0, 6'h3c);
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("busy_hold_ack", 32'(req_ack_o), 32'd0);
        end
        force_busy = 1'b0;
        do_txn(0, 1, "busy_release");

        // Timeout: stub never raises busy
        stub_en = 1'b1;
        k = (ptr_m + 1) % N;
        set_word(k, 6'h27);
        req = N'(1 << k);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (req_ack_o != '0) got = 1'b1;
        end
        chk("tmo_ack_seen", 32'(got), 32'd1);
        chk("tmo_ack", 32'(req_ack_o), 32'(1 << k));
        req = '0;
        ptr_m = (k + 1) % N;
        for (int t = 1; t <= TMO; t++) begin
            tick();
            chk("tmo_err_early", 32'(err_tmo_o), 32'd0);
        end
        tick();
        chk("tmo_err", 32'(err_tmo_o), 32'd1);
        chk("tmo_done", 32'(done_o), 32'd1);
        chk("tmo_done_id", 32'(done_id_o), 32'(k));
        tick();
        chk("tmo_idle", 32'(idle_o), 32'd1);
        chk("tmo_done_pulse", 32'(done_o), 32'd0);
        chk("tmo_done_id_hold", 32'(done_id_o), 32'(k));
        stub_en = 1'b0;
        w = (ptr_m + 2) % N;
        set_word(w, 6'h19);
        req = N'(1 << w);
        do_txn(w, 1, "after_tmo");
        chk("tmo_sticky", 32'(err_tmo_o), 32'd1);

        // Reset while shifting on requester 2
        tick();
        set_word(2, 6'h2d);
        set_word(0, 6'h0f);
        set_word(3, 6'h30);
        req = 4'b0100;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (req_ack_o != '0) got = 1'b1;
        end
        chk("mid_ack_seen", 32'(got), 32'd1);
        req = '0;
        tick();
        tick();
        tick();
        chk("mid_shifting", 32'(ser_busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_idle", 32'(idle_o), 32'd1);
        chk("mid_ack", 32'(req_ack_o), 32'd0);
        chk("mid_val", 32'(ser_val_o), 32'd0);
        chk("mid_data", 32'(ser_data_o), 32'd0);
        chk("mid_done", 32'(done_o), 32'd0);
        chk("mid_done_id", 32'(done_id_o), 32'd0);
        chk("mid_err", 32'(err_tmo_o), 32'd0);
        rst   = 1'b0;
        ptr_m = 0;
        got   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done_o) got = 1'b1;
        end
        chk("mid_no_done", 32'(got), 32'd0);
        req = 4'b1001;
        do_txn(0, 1, "post_rst");
        do_txn(3, 1, "post_rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
